// File: rtl/bus_arbiter_pkg.sv
// Shared types and widths for the IF/MEM bus arbiter.
// The state encodings are also used by debug/trace logic elsewhere in the pipeline.
package bus_arbiter_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_SEL_W  = 4;

  localparam logic [BUS_SEL_W-1:0] SEL_WORD = 4'hF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_MEM  = 2'd2,
    ARB_DROP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// Shares one Wishbone-style bus between the fetch port and the data port,
// one transaction at a time, with flush handling and an ack timeout.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,

  input  logic                  if_req,
  input  logic [BUS_ADDR_W-1:0] if_addr,
  output logic [BUS_DATA_W-1:0] if_rdata,
  output logic                  if_ack,
  output logic                  if_err,

  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [BUS_SEL_W-1:0]  mem_sel,
  input  logic [BUS_ADDR_W-1:0] mem_addr,
  input  logic [BUS_DATA_W-1:0] mem_wdata,
  output logic [BUS_DATA_W-1:0] mem_rdata,
  output logic                  mem_ack,
  output logic                  mem_err,

  output logic                  bus_cyc,
  output logic                  bus_stb,
  output logic                  bus_we,
  output logic [BUS_SEL_W-1:0]  bus_sel,
  output logic [BUS_ADDR_W-1:0] bus_addr,
  output logic [BUS_DATA_W-1:0] bus_wdata,
  input  logic [BUS_DATA_W-1:0] bus_rdata,
  input  logic                  bus_ack,

  output logic                  stallreq_from_if,
  output logic                  stallreq_from_mem
);

  arb_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [BUS_SEL_W-1:0]  sel_q, sel_d;
  logic [BUS_ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
  logic                  timeout_hit;

  // True in the cycle whose missing ack would bring the wait count to TIMEOUT.
  assign timeout_hit = (cnt_q == TIMEOUT - 8'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_ack    = 1'b0;
    if_err    = 1'b0;
    if_rdata  = '0;
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = '0;

    unique case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (mem_req) begin
          state_d = ARB_MEM;
          we_d    = mem_we;
          sel_d   = mem_sel;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
        end else if (if_req && !flush) begin
          state_d = ARB_IF;
          we_d    = 1'b0;
          sel_d   = SEL_WORD;
          addr_d  = if_addr;
          wdata_d = '0;
        end
      end

      ARB_IF: begin
        if (flush) begin
          // A cancelled fetch either finishes silently now or keeps the bus until the slave answers.
          cnt_d   = '0;
          state_d = (bus_ack || timeout_hit) ? ARB_IDLE : ARB_DROP;
        end else if (bus_ack || timeout_hit) begin
          if_ack   = 1'b1;
          if_err   = ~bus_ack;
          if_rdata = bus_ack ? bus_rdata : '0;
          state_d  = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ARB_MEM: begin
        if (bus_ack || timeout_hit) begin
          mem_ack   = 1'b1;
          mem_err   = ~bus_ack;
          mem_rdata = bus_ack ? bus_rdata : '0;
          state_d   = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ARB_DROP: begin
        if (bus_ack || timeout_hit) begin
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = ARB_IDLE;
    endcase

    // Bus fields read as zero whenever no transaction is in flight.
    cyc_d = (state_d != ARB_IDLE);
    if (!cyc_d) begin
      we_d    = 1'b0;
      sel_d   = '0;
      addr_d  = '0;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus_cyc   = cyc_q;
  assign bus_stb   = cyc_q;
  assign bus_we    = we_q;
  assign bus_sel   = sel_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  assign stallreq_from_mem = mem_req & ~mem_ack;
  assign stallreq_from_if  = if_req & ~if_ack & ~flush;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-port arbiter that shares the single external Wishbone-style memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage) of the five-stage pipeline. It runs one bus transaction at a time, holds the request fields in registers for the whole transaction, and returns read data to the requesting port. It also raises per-port stall requests that the pipeline stall controller merges into the `stall[5:0]` vector.

## Interface
- `TIMEOUT`, 8'd255: bus cycles to wait for `bus_ack` before a forced error completion.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset; asserted when 0. Do not use the `RstEnable` macro for it.
- `flush`  in  1  pipeline flush; cancels the pending or in-flight IF access.
- `if_req` / `if_addr`  in  1 / 32  fetch request, word address.
- `if_rdata` / `if_ack` / `if_err`  out  32 / 1 / 1  fetch data, 1-cycle completion pulse, error flag (valid with ack).
- `mem_req` / `mem_we` / `mem_sel` / `mem_addr` / `mem_wdata`  in  1 / 1 / 4 / 32 / 32  data request.
- `mem_rdata` / `mem_ack` / `mem_err`  out  32 / 1 / 1  data return, completion pulse, error flag.
- `bus_cyc`, `bus_stb`, `bus_we`  out  1 each  bus strobes (registered).
- `bus_sel` / `bus_addr` / `bus_wdata`  out  4 / 32 / 32  registered bus fields.
- `bus_rdata` / `bus_ack`  in  32 / 1  slave return.
- `stallreq_from_if` / `stallreq_from_mem`  out  1 each  stall requests (combinational).

## Operation
- FSM states: IDLE, IF_ACC, MEM_ACC, IF_DROP.
- IDLE: when `mem_req` is high, latch the mem fields and go to MEM_ACC. Otherwise, when `if_req` is high and `flush` is low, latch `if_addr` with `we=0` and `sel=4'hF`, then go to IF_ACC. MEM always wins a simultaneous request, because MEM stalls the stages behind IF.
- IF_ACC / MEM_ACC: drive `bus_cyc=bus_stb=1` with the latched fields.
  - On `bus_ack`: pulse the matching `*_ack`, pass `bus_rdata` through to `*_rdata`, drop the strobes, and return to IDLE.
- IF_DROP: entered from IF_ACC when `flush=1` without `bus_ack` in the same cycle. Strobes stay up until `bus_ack`. The ack and data are discarded (`if_ack` stays 0), then the FSM returns to IDLE.
- Flush and `bus_ack` in the same IF_ACC cycle: the ack is suppressed and the FSM goes to IDLE.
- Timeout: an 8-bit counter clears on entry to any ACC/DROP state and increments each cycle without ack. When it reaches `TIMEOUT`, complete with `*_ack=1`, `*_err=1`, `*_rdata=0`, and return to IDLE. In IF_DROP a timeout only returns to IDLE.
- Stall requests:
  - `stallreq_from_mem = mem_req & ~mem_ack`.
  - `stallreq_from_if = if_req & ~if_ack & ~flush`.
- `*_rdata` is 0 except in its ack cycle.

## Timing
- Reset (`rst=0`, asynchronous):
  - state IDLE, counter 0.
  - all bus outputs 0.
  - `if_ack`, `mem_ack`, `if_err`, `mem_err` = 0.
  - `if_rdata`, `mem_rdata` = 0.
- Reset mid-transaction: strobes drop immediately and no ack is issued.
- Latency: request sampled in cycle N, strobes high from N+1. With a zero-wait slave, ack lands in N+1, so the minimum is 2 cycles.
- At least one IDLE cycle separates consecutive transactions; the strobe drops for one cycle.
- Latched request fields stay constant while strobes are high, regardless of port inputs.
- Port inputs may change or drop during a transaction with no effect on the bus. A dropped `mem_req` still completes its bus cycle; its ack is still pulsed and ignored upstream.

## Structure
- Put the FSM state encodings (2-bit `localparam`s `ARB_IDLE`, `ARB_IF`, `ARB_MEM`, `ARB_DROP`) and the bus width constants in `define.v` alongside the existing macros.
- Single module, no sub-modules. The timeout counter is inline.
- Top level ORs `stallreq_from_if` into the existing stall controller as an additional stall source.

## Test plan
- Zero-wait read:
  - Stimulus: `if_req=1`, `if_addr=32'h0000_0100`, slave acks in the first strobe cycle with 32'h2402_0005.
  - Required response: `if_ack` pulses in cycle 1 with that data; `stallreq_from_if` is high only in cycle 0.
- Simultaneous requests:
  - Stimulus: `if_req` and `mem_req` (write, `mem_addr` 32'h0000_2000, `mem_wdata` 32'hDEAD_BEEF, `sel` 4'hF) in the same cycle.
  - Required response: MEM transaction first; IF starts after one IDLE cycle; `stallreq_from_if` is held throughout.
- Flush in flight:
  - Stimulus: `flush` pulses during IF_ACC with a 3-wait slave.
  - Required response: the FSM enters IF_DROP; `if_ack` is never asserted; strobes drop after the slave ack; the next `if_req` is served normally.
- Timeout:
  - Stimulus: `TIMEOUT=8'd4`, slave never acks a mem read.
  - Required response: `mem_ack=1` and `mem_err=1` with `mem_rdata=0` on the 4th wait cycle; the FSM returns to IDLE.
- Reset abort:
  - Stimulus: `rst` drops to 0 mid-MEM_ACC.
  - Required response: `bus_cyc` and `bus_stb` go to 0 asynchronously; no ack is issued; after release the FSM is IDLE.
- Field stability:
  - Stimulus: toggle `mem_addr` and `mem_wdata` every cycle during a 5-wait write.
  - Required response: `bus_addr` and `bus_wdata` stay constant at their sampled values.
